pipeline_hazard_controller: RTL

- Sequences the 5-stage MIPS pipeline around the decode controller.
- Owns PC/IFID write enables, the per-stage write enables (StageWriteEnable) and the flush signals.
- Resolves load-use hazards, taken-branch/jump squashes and the multi-cycle multiply occupying EX.
- Keeps a saturating stall-cycle counter for bring-up.

---
 rtl/pipeline_hazard_controller_pkg.sv | 34 +++
 rtl/pipeline_hazard_controller_if.sv | 49 ++++
 rtl/pipeline_hazard_controller_load_use_detect.sv | 30 +++
 rtl/pipeline_hazard_controller.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
//
// Shared types and constants for the MIPS pipeline hazard controller.
//   state_e         : controller state encodings (INIT, RUN, MUL_WAIT)
//   SWE_*           : bit positions inside StageWriteEnable
//   SWE_ALL         : every stage register advances
//   SWE_HOLD_IDEX   : ID/EX held, EX/MEM and MEM/WB still written
//   MUL_OPCODE      : primary opcode of the multi-cycle multiply
//   isMulOpcode()   : decode helper for the multiply opcode
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_MUL_WAIT = 2'b10
    } state_e;

    localparam int SWE_IDEX  = 0;
    localparam int SWE_EXMEM = 1;
    localparam int SWE_MEMWB = 2;

    localparam logic [2:0] SWE_ALL       = 3'b111;
    localparam logic [2:0] SWE_HOLD_IDEX = 3'b110;

    localparam logic [5:0] MUL_OPCODE = 6'b011100;

    // Lets the decoder produce ID_MulOp from the raw opcode field.
    function automatic logic isMulOpcode(input logic [5:0] opcode);
        return opcode == MUL_OPCODE;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller_if
//
// Bundle between the pipeline datapath/decoder (master) and the hazard
// controller (slave).
//   Hazard inputs  : IFID_Rs, IFID_Rt, ID_UsesRt, ID_MulOp, IDEX_MemRead,
//                    IDEX_Rt, EX_BranchTaken
//   Control outputs: PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
//                    StageWriteEnable, MulStart, MulBusy, StallCount
// COUNT_WIDTH must match the controller's COUNT_WIDTH.
// ---------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
    parameter int COUNT_WIDTH = 32
);
    import pipeline_ctrl_pkg::*;

    logic [4:0]             IFID_Rs;
    logic [4:0]             IFID_Rt;
    logic                   ID_UsesRt;
    logic                   ID_MulOp;
    logic                   IDEX_MemRead;
    logic [4:0]             IDEX_Rt;
    logic                   EX_BranchTaken;

    logic                   PCWrite;
    logic                   IFID_Write;
    logic                   IFID_Flush;
    logic                   IDEX_Flush;
    logic                   EXMEM_Flush;
    logic [2:0]             StageWriteEnable;
    logic                   MulStart;
    logic                   MulBusy;
    logic [COUNT_WIDTH-1:0] StallCount;

    modport master (
        output IFID_Rs, IFID_Rt, ID_UsesRt, ID_MulOp,
               IDEX_MemRead, IDEX_Rt, EX_BranchTaken,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
               StageWriteEnable, MulStart, MulBusy, StallCount
    );

    modport slave (
        input  IFID_Rs, IFID_Rt, ID_UsesRt, ID_MulOp,
               IDEX_MemRead, IDEX_Rt, EX_BranchTaken,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
               StageWriteEnable, MulStart, MulBusy, StallCount
    );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//
// Purely combinational load-use hazard compare between the load in EX and
// the source registers of the instruction in ID.
//   idexMemRead_i : EX instruction is a load
//   idexRt_i      : load destination register
//   ifidRs_i      : rs of ID instruction (always a source)
//   ifidRt_i      : rt of ID instruction
//   idUsesRt_i    : ID instruction actually reads rt
//   loadHazard_o  : ID must wait one cycle for the load data
// ---------------------------------------------------------------------------
module load_use_detect (
    input  logic       idexMemRead_i,
    input  logic [4:0] idexRt_i,
    input  logic [4:0] ifidRs_i,
    input  logic [4:0] ifidRt_i,
    input  logic       idUsesRt_i,
    output logic       loadHazard_o
);

    // $zero is never really written, so a load targeting it cannot hazard.
    always_comb begin
        loadHazard_o = idexMemRead_i
                     & (idexRt_i != 5'd0)
                     & ((idexRt_i == ifidRs_i)
                        | (idUsesRt_i & (idexRt_i == ifidRt_i)));
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Sequences the 5-stage MIPS pipeline: PC/IFID enables, per-stage write
// enables, flushes, load-use stalls, branch squashes and the multi-cycle
// multiply that occupies EX. Also keeps a saturating stall-cycle counter.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   ctrl_if : slave side of pipeline_hazard_controller_if
// Parameters:
//   MUL_LATENCY : total EX cycles a multiply occupies (2..16)
//   COUNT_WIDTH : width of StallCount
// ---------------------------------------------------------------------------
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_hazard_controller_if.slave   ctrl_if
);

    // The first MUL_WAIT cycle is already one of the MUL_LATENCY EX cycles.
    localparam logic [3:0]             MUL_RELOAD = 4'(MUL_LATENCY - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    state_e                 state_q, state_d;
    logic [3:0]             mulCnt_q, mulCnt_d;
    logic                   mulStart_q, mulStart_d;
    logic [COUNT_WIDTH-1:0] stallCount_q, stallCount_d;

    logic       loadHazard;
    logic       runEval;
    logic       pcWrite;
    logic       ifidWrite;
    logic       ifidFlush;
    logic       idexFlush;
    logic       exmemFlush;
    logic [2:0] stageWe;
    logic       mulBusy;

    load_use_detect u_loadUseDetect (
        .idexMemRead_i (ctrl_if.IDEX_MemRead),
        .idexRt_i      (ctrl_if.IDEX_Rt),
        .ifidRs_i      (ctrl_if.IFID_Rs),
        .ifidRt_i      (ctrl_if.IFID_Rt),
        .idUsesRt_i    (ctrl_if.ID_UsesRt),
        .loadHazard_o  (loadHazard)
    );

    // State register, multiply countdown, start pulse and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            mulCnt_q     <= 4'd0;
            mulStart_q   <= 1'b0;
            stallCount_q <= '0;
        end else begin
            state_q      <= state_d;
            mulCnt_q     <= mulCnt_d;
            mulStart_q   <= mulStart_d;
            stallCount_q <= stallCount_d;
        end
    end

    // Next-state and Mealy outputs. The release cycle of a multiply behaves
    // exactly like a RUN cycle, so both share the runEval decision below;
    // that is what lets a second multiply start without an idle RUN cycle.
    always_comb begin
        state_d    = state_q;
        mulCnt_d   = mulCnt_q;
        mulStart_d = 1'b0;
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;
        stageWe    = 3'b000;
        mulBusy    = 1'b0;
        runEval    = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                runEval = 1'b1;
            end
            ST_MUL_WAIT: begin
                if (mulCnt_q != 4'd0) begin
                    // EX holds the multiply, so a taken branch cannot be in EX
                    // and EX_BranchTaken is deliberately not looked at here.
                    mulBusy    = 1'b1;
                    stageWe    = SWE_HOLD_IDEX;
                    exmemFlush = 1'b1;
                    mulCnt_d   = mulCnt_q - 4'd1;
                end else begin
                    runEval = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (runEval) begin
            state_d   = ST_RUN;
            pcWrite   = 1'b1;
            ifidWrite = 1'b1;
            stageWe   = SWE_ALL;
            if (ctrl_if.EX_BranchTaken) begin
                // The ID instruction is squashed, so its hazards are moot.
                ifidFlush = 1'b1;
                idexFlush = 1'b1;
            end else if (loadHazard) begin
                pcWrite   = 1'b0;
                ifidWrite = 1'b0;
                idexFlush = 1'b1;
            end else if (ctrl_if.ID_MulOp) begin
                state_d    = ST_MUL_WAIT;
                mulCnt_d   = MUL_RELOAD;
                mulStart_d = 1'b1;
            end
        end
    end

    // Stall counter for bring-up; saturates rather than wrapping so a long
    // run never appears to have stalled less than it did.
    always_comb begin
        stallCount_d = stallCount_q;
        if ((state_q != ST_INIT) && !pcWrite && (stallCount_q != COUNT_MAX)) begin
            stallCount_d = stallCount_q + COUNT_WIDTH'(1);
        end
    end

    assign ctrl_if.PCWrite          = pcWrite;
    assign ctrl_if.IFID_Write       = ifidWrite;
    assign ctrl_if.IFID_Flush       = ifidFlush;
    assign ctrl_if.IDEX_Flush       = idexFlush;
    assign ctrl_if.EXMEM_Flush      = exmemFlush;
    assign ctrl_if.StageWriteEnable = stageWe;
    assign ctrl_if.MulStart         = mulStart_q;
    assign ctrl_if.MulBusy          = mulBusy;
    assign ctrl_if.StallCount       = stallCount_q;

endmodule
